// File: rtl/lsb_queue_if.sv
// Memory-side request/response bus of the load/store buffer.
// master = buffer issuing requests, slave = memory answering them.
interface lsb_queue_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_size;
  logic        mem_done;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_size,
    input  mem_done, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_size,
    output mem_done, mem_rdata
  );
endinterface

// File: rtl/lsb_queue.sv
// In-order load/store buffer: loads execute at the head, stores only once committed.
// A ROB clear keeps the committed-store prefix and flushes everything behind it.
module lsb_queue #(
  parameter int LSB_WIDTH = 3,
  parameter int LSB_SIZE  = 8,
  parameter int ROB_WIDTH = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clear,
  input  logic                 from_rs,
  input  logic [ROB_WIDTH-1:0] from_rs_tag,
  input  logic                 from_rs_store,
  input  logic [2:0]           from_rs_f3,
  input  logic [31:0]          from_rs_addr,
  input  logic [31:0]          from_rs_sdata,
  input  logic                 from_rob,
  input  logic [ROB_WIDTH-1:0] from_rob_tag,
  output logic                 to_rob,
  output logic [ROB_WIDTH-1:0] to_rob_tag,
  output logic [31:0]          to_rob_wdata,
  output logic                 to_if_space,
  lsb_queue_if.master          mem
);

  typedef enum logic [1:0] {IDLE, BUSY, DISCARD} state_t;

  state_t               state;
  logic [LSB_WIDTH-1:0] head, tail, head_next, tail_next;
  logic [LSB_WIDTH:0]   count, count_next, ncommit, keep;
  logic [LSB_SIZE-1:0]  committed, commit_next, valid;
  logic                 do_push, do_pop, scan_run;
  logic [LSB_WIDTH-1:0] scan_idx, offs;

  logic [ROB_WIDTH-1:0] e_tag   [LSB_SIZE];
  logic [2:0]           e_f3    [LSB_SIZE];
  logic [31:0]          e_addr  [LSB_SIZE];
  logic [31:0]          e_sdata [LSB_SIZE];
  logic [LSB_SIZE-1:0]  e_store;

  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] r);
    case (f3)
      3'b000:  return {{24{r[7]}}, r[7:0]};
      3'b001:  return {{16{r[15]}}, r[15:0]};
      3'b100:  return {24'b0, r[7:0]};
      3'b101:  return {16'b0, r[15:0]};
      default: return r;
    endcase
  endfunction

  always_comb begin
    valid       = '0;
    commit_next = committed;
    offs        = '0;
    for (int unsigned i = 0; i < LSB_SIZE; i++) begin
      offs     = LSB_WIDTH'(i) - head;
      valid[i] = ({1'b0, offs} < count);
      if (from_rob && valid[i] && e_tag[i] == from_rob_tag)
        commit_next[i] = 1'b1;
    end

    // Committed stores form a contiguous prefix from head; stop at the first gap.
    ncommit  = '0;
    scan_run = 1'b1;
    scan_idx = '0;
    for (int unsigned i = 0; i < LSB_SIZE; i++) begin
      scan_idx = head + LSB_WIDTH'(i);
      if (scan_run && ((LSB_WIDTH+1)'(i) < count) && e_store[scan_idx] && commit_next[scan_idx])
        ncommit = ncommit + 1'b1;
      else
        scan_run = 1'b0;
    end
  end

  always_comb begin
    do_pop    = (state == BUSY) && mem.mem_done;
    do_push   = from_rs && !clear && (count != (LSB_WIDTH+1)'(LSB_SIZE));
    keep      = (do_pop && ncommit == '0) ? (LSB_WIDTH+1)'(1) : ncommit;
    head_next = head + LSB_WIDTH'(do_pop);
    if (clear) begin
      tail_next  = head + keep[LSB_WIDTH-1:0];
      count_next = keep - (LSB_WIDTH+1)'(do_pop);
    end else begin
      tail_next  = tail + LSB_WIDTH'(do_push);
      count_next = count + (LSB_WIDTH+1)'(do_push) - (LSB_WIDTH+1)'(do_pop);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rdy_in && do_push) begin
      e_tag[tail]   <= from_rs_tag;
      e_f3[tail]    <= from_rs_f3;
      e_addr[tail]  <= from_rs_addr;
      e_sdata[tail] <= from_rs_sdata;
      e_store[tail] <= from_rs_store;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      committed     <= '0;
      state         <= IDLE;
      to_rob        <= 1'b0;
      to_rob_tag    <= '0;
      to_rob_wdata  <= '0;
      to_if_space   <= 1'b1;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      mem.mem_size  <= '0;
    end else if (rdy_in) begin
      head        <= head_next;
      tail        <= tail_next;
      count       <= count_next;
      to_if_space <= (32'(count_next) + 32'd2) < 32'(LSB_SIZE);
      committed   <= commit_next;
      if (do_push)
        committed[tail] <= 1'b0;
      to_rob <= 1'b0;

      case (state)
        IDLE: begin
          if (count != '0 && !clear && (!e_store[head] || commit_next[head])) begin
            state         <= BUSY;
            mem.mem_req   <= 1'b1;
            mem.mem_we    <= e_store[head];
            mem.mem_addr  <= e_addr[head];
            mem.mem_wdata <= e_sdata[head];
            mem.mem_size  <= e_f3[head][1:0];
          end
        end
        BUSY: begin
          if (mem.mem_done) begin
            mem.mem_req <= 1'b0;
            state       <= IDLE;
            if (!e_store[head] && !clear) begin
              to_rob       <= 1'b1;
              to_rob_tag   <= e_tag[head];
              to_rob_wdata <= extend(e_f3[head], mem.mem_rdata);
            end
          end else if (clear && !e_store[head]) begin
            state <= DISCARD;
          end
        end
        // The flushed load was already dropped from head/count by the clear,
        // so completion here only retires the bus transaction.
        DISCARD: begin
          if (mem.mem_done) begin
            mem.mem_req <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsb_queue.sv
// Directed and randomized checks of lsb_queue against a queue-based reference model.
module tb_lsb_queue;
  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        clear = 1'b0;
  logic        from_rs = 1'b0;
  logic [3:0]  from_rs_tag = '0;
  logic        from_rs_store = 1'b0;
  logic [2:0]  from_rs_f3 = '0;
  logic [31:0] from_rs_addr = '0;
  logic [31:0] from_rs_sdata = '0;
  logic        from_rob = 1'b0;
  logic [3:0]  from_rob_tag = '0;
  logic        to_rob;
  logic [3:0]  to_rob_tag;
  logic [31:0] to_rob_wdata;
  logic        to_if_space;

  lsb_queue_if mem_bus();

  int nerr = 0;
  int nchk = 0;

  typedef struct {
    logic        st;
    logic [3:0]  tag;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic        cm;
  } ent_t;

  ent_t q[$];

  logic [2:0]  t2_f3 [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
  logic [31:0] t2_rd [4] = '{32'h80, 32'h80, 32'h8001, 32'h8001};
  logic [31:0] t2_ex [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001};
  logic [2:0]  ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  always #5 clk_in = ~clk_in;

  lsb_queue #(.LSB_WIDTH(3), .LSB_SIZE(8), .ROB_WIDTH(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .from_rs(from_rs), .from_rs_tag(from_rs_tag), .from_rs_store(from_rs_store),
    .from_rs_f3(from_rs_f3), .from_rs_addr(from_rs_addr), .from_rs_sdata(from_rs_sdata),
    .from_rob(from_rob), .from_rob_tag(from_rob_tag),
    .to_rob(to_rob), .to_rob_tag(to_rob_tag), .to_rob_wdata(to_rob_wdata),
    .to_if_space(to_if_space), .mem(mem_bus)
  );

  function automatic logic [31:0] ext_model(input logic [2:0] f3, input logic [31:0] r);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = r[7:0];
    h = r[15:0];
    case (f3)
      3'b000:  return int'(b);
      3'b001:  return int'(h);
      3'b100:  return 32'(r[7:0]);
      3'b101:  return 32'(r[15:0]);
      default: return r;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push(input logic st, input logic [3:0] tag, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] d);
    from_rs = 1'b1; from_rs_store = st; from_rs_tag = tag;
    from_rs_f3 = f3; from_rs_addr = a; from_rs_sdata = d;
    tick();
    from_rs = 1'b0;
  endtask

  task automatic serve(input logic [31:0] rd);
    mem_bus.mem_done = 1'b1;
    mem_bus.mem_rdata = rd;
    tick();
    mem_bus.mem_done = 1'b0;
  endtask

  task automatic wait_req(input string tag, input int max);
    int n = 0;
    while (!mem_bus.mem_req && n < max) begin
      tick();
      n++;
    end
    chk(tag, 32'(mem_bus.mem_req), 32'd1);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    int rh;
    int pushed;
    int retired;
    int lat;
    bit inflight;
    bit dd;
    logic [31:0] rd_last;
    logic [3:0]  tagc;
    ent_t cur;
    ent_t ne;

    mem_bus.mem_done = 1'b0;
    mem_bus.mem_rdata = '0;

    // reset
    tick(); tick();
    chk("rst_to_rob", 32'(to_rob), 0);
    chk("rst_mem_req", 32'(mem_bus.mem_req), 0);
    chk("rst_mem_we", 32'(mem_bus.mem_we), 0);
    chk("rst_space", 32'(to_if_space), 1);
    chk("rst_wdata", to_rob_wdata, 0);
    chk("rst_addr", mem_bus.mem_addr, 0);
    chk("rst_count", 32'(dut.count), 0);
    rst_in = 1'b0;
    tick();

    // 1: single word load
    push(1'b0, 4'd3, 3'b010, 32'h100, 32'h0);
    chk("t1_req_before", 32'(mem_bus.mem_req), 0);
    tick();
    chk("t1_req_latency", 32'(mem_bus.mem_req), 1);
    chk("t1_we", 32'(mem_bus.mem_we), 0);
    chk("t1_addr", mem_bus.mem_addr, 32'h100);
    chk("t1_size", 32'(mem_bus.mem_size), 2);
    serve(32'hDEADBEEF);
    chk("t1_to_rob", 32'(to_rob), 1);
    chk("t1_tag", 32'(to_rob_tag), 3);
    chk("t1_wdata", to_rob_wdata, 32'hDEADBEEF);
    chk("t1_count", 32'(dut.count), 0);
    chk("t1_req_drop", 32'(mem_bus.mem_req), 0);
    tick();
    chk("t1_pulse", 32'(to_rob), 0);

    // 2: sub-word extension
    for (int i = 0; i < 4; i++) begin
      push(1'b0, 4'(4 + i), t2_f3[i], 32'h300 + 32'(4 * i), 32'h0);
      wait_req("t2_req", 4);
      chk("t2_size", 32'(mem_bus.mem_size), 32'(t2_f3[i][1:0]));
      serve(t2_rd[i]);
      chk("t2_to_rob", 32'(to_rob), 1);
      chk("t2_tag", 32'(to_rob_tag), 32'(4 + i));
      chk("t2_wdata", to_rob_wdata, t2_ex[i]);
    end
    tick();

    // 3: store waits for commit
    push(1'b1, 4'd5, 3'b010, 32'h200, 32'h12345678);
    hi = 0;
    repeat (10) begin
      tick();
      if (mem_bus.mem_req) hi++;
    end
    chk("t3_store_waits", 32'(hi), 0);
    from_rob = 1'b1; from_rob_tag = 4'd5;
    tick();
    from_rob = 1'b0;
    chk("t3_req", 32'(mem_bus.mem_req), 1);
    chk("t3_we", 32'(mem_bus.mem_we), 1);
    chk("t3_addr", mem_bus.mem_addr, 32'h200);
    chk("t3_wdata", mem_bus.mem_wdata, 32'h12345678);
    serve(32'h0);
    chk("t3_no_rob", 32'(to_rob), 0);
    chk("t3_req_drop", 32'(mem_bus.mem_req), 0);
    chk("t3_count", 32'(dut.count), 0);

    // 4: clear keeps committed store prefix (commit in the same cycle as clear)
    push(1'b1, 4'd1, 3'b010, 32'h400, 32'hA5A5A5A5);
    push(1'b0, 4'd2, 3'b010, 32'h404, 32'h0);
    push(1'b1, 4'd3, 3'b000, 32'h408, 32'h77);
    chk("t4_count3", 32'(dut.count), 3);
    from_rob = 1'b1; from_rob_tag = 4'd1; clear = 1'b1;
    tick();
    from_rob = 1'b0; clear = 1'b0;
    chk("t4_count_clear", 32'(dut.count), 1);
    wait_req("t4_req", 4);
    chk("t4_we", 32'(mem_bus.mem_we), 1);
    chk("t4_addr", mem_bus.mem_addr, 32'h400);
    chk("t4_wdata", mem_bus.mem_wdata, 32'hA5A5A5A5);
    serve(32'h0);
    chk("t4_no_rob", 32'(to_rob), 0);
    chk("t4_count0", 32'(dut.count), 0);
    hi = 0; rh = 0;
    repeat (5) begin
      tick();
      if (mem_bus.mem_req) hi++;
      if (to_rob) rh++;
    end
    chk("t4_no_more_req", 32'(hi), 0);
    chk("t4_no_more_rob", 32'(rh), 0);

    // push together with clear is dropped
    from_rs = 1'b1; from_rs_store = 1'b0; from_rs_tag = 4'd9; clear = 1'b1;
    tick();
    from_rs = 1'b0; clear = 1'b0;
    chk("push_clear_drop", 32'(dut.count), 0);

    // rdy_in low freezes state
    rdy_in = 1'b0; from_rs = 1'b1;
    tick();
    from_rs = 1'b0; rdy_in = 1'b1;
    chk("rdy_freeze", 32'(dut.count), 0);

    // 5: in-flight load flushed
    push(1'b0, 4'd7, 3'b010, 32'h500, 32'h0);
    tick();
    chk("t5_req", 32'(mem_bus.mem_req), 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t5_req_held", 32'(mem_bus.mem_req), 1);
    chk("t5_count", 32'(dut.count), 0);
    tick(); tick();
    serve(32'h11111111);
    chk("t5_no_rob", 32'(to_rob), 0);
    chk("t5_req_drop", 32'(mem_bus.mem_req), 0);
    chk("t5_count0", 32'(dut.count), 0);
    push(1'b0, 4'd8, 3'b010, 32'h504, 32'h0);
    tick();
    chk("t5_idle_restart", 32'(mem_bus.mem_req), 1);
    chk("t5_idle_addr", mem_bus.mem_addr, 32'h504);
    serve(32'h22);
    chk("t5_next_rob", 32'(to_rob), 1);
    chk("t5_next_tag", 32'(to_rob_tag), 8);

    // mem_done together with clear on a load
    push(1'b0, 4'd9, 3'b010, 32'h508, 32'h0);
    tick();
    chk("t5b_req", 32'(mem_bus.mem_req), 1);
    mem_bus.mem_done = 1'b1; mem_bus.mem_rdata = 32'h33; clear = 1'b1;
    tick();
    mem_bus.mem_done = 1'b0; clear = 1'b0;
    chk("t5b_no_rob", 32'(to_rob), 0);
    chk("t5b_count", 32'(dut.count), 0);
    tick();
    chk("t5b_no_req", 32'(mem_bus.mem_req), 0);

    // 6: fill, space flag, overflow ignored
    for (int i = 0; i < 8; i++) begin
      push(1'b0, 4'(i), 3'b010, 32'h600 + 32'(4 * i), 32'h0);
      chk("t6_space", 32'(to_if_space), 32'((i + 1 + 2) < 8));
    end
    push(1'b0, 4'd15, 3'b010, 32'h6F0, 32'h0);
    chk("t6_full_count", 32'(dut.count), 8);
    for (int k = 0; k < 8; k++) begin
      wait_req("t6_req", 8);
      chk("t6_addr", mem_bus.mem_addr, 32'h600 + 32'(4 * k));
      serve(32'(k) * 32'h1000 + 32'(k));
      chk("t6_rob", 32'(to_rob), 1);
      chk("t6_tag", 32'(to_rob_tag), 32'(k));
    end
    hi = 0;
    repeat (4) begin
      tick();
      if (mem_bus.mem_req) hi++;
    end
    chk("t6_overflow_ignored", 32'(hi), 0);
    chk("t6_count0", 32'(dut.count), 0);

    // randomized traffic with wrap-around against the queue model
    pushed = 0; retired = 0; inflight = 1'b0; dd = 1'b0; lat = 0;
    rd_last = '0; tagc = '0;
    for (int cyc = 0; cyc < 4000 && retired < 40; cyc++) begin
      if (dd) begin
        cur = q.pop_front();
        if (cur.st) begin
          chk("rnd_store_no_rob", 32'(to_rob), 0);
        end else begin
          chk("rnd_rob", 32'(to_rob), 1);
          chk("rnd_tag", 32'(to_rob_tag), 32'(cur.tag));
          chk("rnd_wdata", to_rob_wdata, ext_model(cur.f3, rd_last));
        end
        retired++;
        dd = 1'b0;
      end else begin
        chk("rnd_idle_rob", 32'(to_rob), 0);
      end
      chk("rnd_space", 32'(to_if_space), 32'((q.size() + 2) < 8));

      mem_bus.mem_done = 1'b0; from_rs = 1'b0; from_rob = 1'b0;
      if (mem_bus.mem_req && !inflight) begin
        if (q.size() == 0) begin
          chk("rnd_spurious_req", 32'(mem_bus.mem_req), 0);
        end else begin
          chk("rnd_addr", mem_bus.mem_addr, q[0].addr);
          chk("rnd_we", 32'(mem_bus.mem_we), 32'(q[0].st));
          chk("rnd_size", 32'(mem_bus.mem_size), 32'(q[0].f3[1:0]));
          if (q[0].st) chk("rnd_sdata", mem_bus.mem_wdata, q[0].sdata);
          inflight = 1'b1;
          lat = $urandom_range(0, 3);
        end
      end
      if (inflight) begin
        if (lat == 0) begin
          rd_last = $urandom;
          mem_bus.mem_done = 1'b1;
          mem_bus.mem_rdata = rd_last;
          dd = 1'b1;
          inflight = 1'b0;
        end else begin
          lat--;
        end
      end
      if (q.size() > 0 && q[0].st && !q[0].cm && $urandom_range(0, 1) == 1) begin
        from_rob = 1'b1;
        from_rob_tag = q[0].tag;
        q[0].cm = 1'b1;
      end
      if (pushed < 40 && q.size() < 8 && $urandom_range(0, 2) != 0) begin
        ne.st = ($urandom_range(0, 2) == 0);
        ne.tag = tagc;
        ne.f3 = ne.st ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)];
        ne.addr = $urandom;
        ne.sdata = $urandom;
        ne.cm = 1'b0;
        from_rs = 1'b1; from_rs_store = ne.st; from_rs_tag = ne.tag;
        from_rs_f3 = ne.f3; from_rs_addr = ne.addr; from_rs_sdata = ne.sdata;
        q.push_back(ne);
        tagc = tagc + 4'd1;
        pushed++;
      end
      tick();
    end
    from_rs = 1'b0; from_rob = 1'b0; mem_bus.mem_done = 1'b0;
    chk("rnd_retired", 32'(retired), 32'd40);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
